// File: rtl/pc_fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl_if
//
// Purpose:
//    Bundles the signals shared by the fetch controller, the pipeline control
//    unit and the instruction memory. The controller connects through the
//    master modport. The surrounding pipeline or memory model, or a bench,
//    connects through the slave modport.
//
// Signals (direction seen from the master / controller):
//    stall          in   pipeline stall; pc does not advance while high
//    flush          in   exception/flush redirect request
//    flush_pc       in   flush target address               [ADDR_W]
//    branch_flag    in   branch/jump redirect request
//    branch_target  in   branch target address              [ADDR_W]
//    imem_ready     in   instruction memory accepts the current request
//    pc             out  registered fetch address            [ADDR_W]
//    ce             out  registered memory enable / request valid
//    fetch_fire     out  combinational ce & imem_ready & ~stall
//    held           out  registered, high while the controller is held
//    misalign       out  registered misaligned-target flag
//                        (present only when PC_MISALIGN_CHECK_EN is defined)
//
// Build option:
//    PC_MISALIGN_CHECK_EN adds the misalign signal to both modports.
// ---------------------------------------------------------------------------
interface pc_fetch_ctrl_if #(
   parameter int ADDR_W = 32
);

   logic              stall;
   logic              flush;
   logic [ADDR_W-1:0] flush_pc;
   logic              branch_flag;
   logic [ADDR_W-1:0] branch_target;
   logic              imem_ready;
   logic [ADDR_W-1:0] pc;
   logic              ce;
   logic              fetch_fire;
   logic              held;
`ifdef PC_MISALIGN_CHECK_EN
   logic              misalign;
`endif

`ifdef PC_MISALIGN_CHECK_EN
   // The controller drives the fetch request and the misalign flag.
   modport master (
      input  stall, flush, flush_pc, branch_flag, branch_target, imem_ready,
      output pc, ce, fetch_fire, held, misalign
   );

   // The pipeline and memory side drive the control inputs.
   modport slave (
      output stall, flush, flush_pc, branch_flag, branch_target, imem_ready,
      input  pc, ce, fetch_fire, held, misalign
   );
`else
   // The controller drives the fetch request.
   modport master (
      input  stall, flush, flush_pc, branch_flag, branch_target, imem_ready,
      output pc, ce, fetch_fire, held
   );

   // The pipeline and memory side drive the control inputs.
   modport slave (
      output stall, flush, flush_pc, branch_flag, branch_target, imem_ready,
      input  pc, ce, fetch_fire, held
   );
`endif

endinterface

// File: rtl/pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl
//
// Purpose:
//    Program counter and fetch request generator for the IF stage. It drives
//    the instruction memory address and enable, and follows the
//    ready/stall handshake. It accepts flush and branch redirects. A branch
//    that arrives while fetch cannot proceed is kept in a one-entry pending
//    buffer, so that redirect is not lost.
//
// Parameters:
//    ADDR_W       width of pc and of every target address
//    RESET_VEC    pc loaded on reset; this is the first address fetched
//    INC          byte increment applied on every accepted fetch
//    HOLD_CYCLES  number of cycles ce stays low after rst drops (1..15)
//
// Ports:
//    clk          clock; all logic runs on the rising edge
//    rst          synchronous, active-high reset
//    bus          pc_fetch_ctrl_if.master. Carries stall, flush, flush_pc,
//                 branch_flag, branch_target and imem_ready in, and drives
//                 pc, ce, fetch_fire, held (and misalign) out
//
// Build option:
//    PC_MISALIGN_CHECK_EN. When defined, any target loaded into pc whose low
//    two bits are non-zero raises misalign and removes ce. Only a later
//    flush can clear misalign. When undefined, targets load unchanged.
// ---------------------------------------------------------------------------
module pc_fetch_ctrl #(
   parameter int                ADDR_W      = 32,
   parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
   parameter int                INC         = 4,
   parameter int                HOLD_CYCLES = 1
) (
   input logic             clk,
   input logic             rst,
   pc_fetch_ctrl_if.master bus
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HELD
   } state_t;

   state_t            state;
   logic [3:0]        hold_cnt;
   logic [ADDR_W-1:0] pc_q;
   logic              ce_q;
   logic              held_q;
   logic              pending_vld;
   logic [ADDR_W-1:0] pending_pc;

   logic              fire;
   logic [ADDR_W-1:0] pc_nxt;
   logic              load_tgt;
   logic              pend_vld_nxt;
   logic [ADDR_W-1:0] pend_pc_nxt;

   // A fetch is accepted only when a request is valid, memory takes it and
   // the pipeline can take the result. ce is low in IDLE, so nothing fires
   // there.
   assign fire = ce_q & bus.imem_ready & ~bus.stall;

   // Redirect priority while fetching: flush, then a branch that can go now,
   // then a branch that must wait, then a waiting branch, then a plain
   // increment. A branch that goes straight through also drops any older
   // pending target, so the stale target cannot be fetched later.
   // load_tgt marks the cases where pc takes a target address rather than
   // an increment. Those are the loads that the misalign check watches.
   always_comb begin
      pc_nxt       = pc_q;
      load_tgt     = 1'b0;
      pend_vld_nxt = pending_vld;
      pend_pc_nxt  = pending_pc;
      if (bus.flush) begin
         pc_nxt       = bus.flush_pc;
         load_tgt     = 1'b1;
         pend_vld_nxt = 1'b0;
      end else if (bus.branch_flag && fire) begin
         pc_nxt       = bus.branch_target;
         load_tgt     = 1'b1;
         pend_vld_nxt = 1'b0;
      end else if (bus.branch_flag) begin
         pend_pc_nxt  = bus.branch_target;
         pend_vld_nxt = 1'b1;
      end else if (pending_vld && fire) begin
         pc_nxt       = pending_pc;
         load_tgt     = 1'b1;
         pend_vld_nxt = 1'b0;
      end else if (fire) begin
         pc_nxt       = pc_q + ADDR_W'(INC);
      end
   end

`ifdef PC_MISALIGN_CHECK_EN
   logic misalign_q;
   logic misalign_nxt;

   // A flush always sets misalign again from its own target. A flush to an
   // aligned address is therefore the only way out of the misaligned
   // condition. Any other target load can only set the flag.
   always_comb begin
      misalign_nxt = misalign_q;
      if (bus.flush) begin
         misalign_nxt = (bus.flush_pc[1:0] != 2'b00);
      end else if (load_tgt && (pc_nxt[1:0] != 2'b00)) begin
         misalign_nxt = 1'b1;
      end
   end

   // The misalign flag updates only while fetching. Reset clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         misalign_q <= 1'b0;
      end else if (state != IDLE) begin
         misalign_q <= misalign_nxt;
      end
   end

   assign bus.misalign = misalign_q;
`else
   logic misalign_nxt;

   // Without the check, nothing ever stops ce once fetching has started.
   assign misalign_nxt = 1'b0;
`endif

   // Main controller. IDLE counts out the post-reset hold, then fetching
   // starts at RESET_VEC. RUN and HELD share the same datapath update. The
   // only difference between them is whether the last cycle accepted a
   // fetch or a flush, and the registered held output reports that.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         hold_cnt    <= 4'd0;
         pc_q        <= RESET_VEC;
         ce_q        <= 1'b0;
         held_q      <= 1'b0;
         pending_vld <= 1'b0;
         pending_pc  <= '0;
      end else begin
         case (state)
            IDLE: begin
               hold_cnt <= hold_cnt + 4'd1;
               if (hold_cnt == 4'(HOLD_CYCLES - 1)) begin
                  ce_q  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN, HELD: begin
               pc_q        <= pc_nxt;
               pending_vld <= pend_vld_nxt;
               pending_pc  <= pend_pc_nxt;
               ce_q        <= ~misalign_nxt;
               if (fire || bus.flush) begin
                  state  <= RUN;
                  held_q <= 1'b0;
               end else begin
                  state  <= HELD;
                  held_q <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.pc         = pc_q;
   assign bus.ce         = ce_q;
   assign bus.fetch_fire = fire;
   assign bus.held       = held_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_ctrl
//
// Self-checking bench for pc_fetch_ctrl using its default parameters
// (ADDR_W=32, RESET_VEC=0, INC=4, HOLD_CYCLES=1). A behavioural model keeps
// the expected pc, enable, held flag and pending branch. The pending branch
// is held in a queue that has at most one entry. Directed scenarios come
// first. A randomized run then compares the DUT with the model on every
// cycle. When PC_MISALIGN_CHECK_EN is defined, the misalign path is covered
// too.
// ---------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

   logic clk;
   logic rst;

   pc_fetch_ctrl_if #(.ADDR_W(32)) bus ();

   pc_fetch_ctrl #(
      .ADDR_W     (32),
      .RESET_VEC  (32'h0),
      .INC        (4),
      .HOLD_CYCLES(1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.master)
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state.
   logic [31:0] m_pc;
   bit          m_ce;
   bit          m_held;
   bit          m_active;
   int          m_edges;
   logic [31:0] m_pend[$];
   bit          m_mis;

   // Fetch-fire values recorded by the last applyStimulus call.
   bit obs_fire;
   bit exp_fire;

   // Advances the model by one rising edge, using the inputs present at
   // that edge. Fetching starts HOLD_CYCLES edges after reset is released.
   task automatic model_step(input bit r, input bit st, input bit fl,
                             input logic [31:0] fpc, input bit br,
                             input logic [31:0] bt, input bit rdy);
      bit f;
      bit loaded;
      f      = m_ce && rdy && !st;
      loaded = 1'b0;
      if (r) begin
         m_pc     = 32'h0;
         m_ce     = 1'b0;
         m_held   = 1'b0;
         m_active = 1'b0;
         m_edges  = 0;
         m_mis    = 1'b0;
         m_pend.delete();
      end else if (!m_active) begin
         m_edges++;
         if (m_edges == 1) begin
            m_active = 1'b1;
            m_ce     = 1'b1;
         end
      end else begin
         if (fl) begin
            m_pc = fpc;
            m_pend.delete();
         end else if (br && f) begin
            m_pc = bt;
            loaded = 1'b1;
            m_pend.delete();
         end else if (br) begin
            m_pend.delete();
            m_pend.push_back(bt);
         end else if (m_pend.size() > 0 && f) begin
            m_pc = m_pend.pop_front();
            loaded = 1'b1;
         end else if (f) begin
            m_pc = m_pc + 32'd4;
         end
         m_held = !(f || fl);
`ifdef PC_MISALIGN_CHECK_EN
         if (fl) m_mis = (fpc % 4) != 0;
         else if (loaded && (m_pc % 4) != 0) m_mis = 1'b1;
         m_ce = !m_mis;
`endif
      end
   endtask

   // Drives one cycle of inputs. It records the fetch_fire seen before the
   // edge, steps the model, and returns 1 time unit after the rising edge.
   task automatic applyStimulus(input bit r, input bit st, input bit fl,
                                input logic [31:0] fpc, input bit br,
                                input logic [31:0] bt, input bit rdy);
      rst               = r;
      bus.stall         = st;
      bus.flush         = fl;
      bus.flush_pc      = fpc;
      bus.branch_flag   = br;
      bus.branch_target = bt;
      bus.imem_ready    = rdy;
      #1;
      obs_fire = bus.fetch_fire;
      exp_fire = m_ce && rdy && !st;
      model_step(r, st, fl, fpc, br, bt, rdy);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      applyStimulus(1, 0, 0, 0, 0, 0, 1);
      applyStimulus(1, 0, 0, 0, 0, 0, 1);
      n_checks++;
      if (bus.pc !== 32'h0) $display("[TB] FAIL reset_pc: got %h want %h", bus.pc, 32'h0);
      else n_pass++;
      n_checks++;
      if (bus.ce !== 1'b0) $display("[TB] FAIL reset_ce: got %b want 0", bus.ce);
      else n_pass++;
      n_checks++;
      if (bus.held !== 1'b0) $display("[TB] FAIL reset_held: got %b want 0", bus.held);
      else n_pass++;
   endtask

   task automatic test_startup();
      logic [31:0] want[3];
      want[0] = 32'h0;
      want[1] = 32'h4;
      want[2] = 32'h8;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 1);
         n_checks++;
         if (bus.ce !== 1'b1) $display("[TB] FAIL startup_ce[%0d]: got %b want 1", i, bus.ce);
         else n_pass++;
         n_checks++;
         if (bus.pc !== want[i]) $display("[TB] FAIL startup_pc[%0d]: got %h want %h", i, bus.pc, want[i]);
         else n_pass++;
         n_checks++;
         if (bus.fetch_fire !== 1'b1) $display("[TB] FAIL startup_fire[%0d]: got %b want 1", i, bus.fetch_fire);
         else n_pass++;
      end
   endtask

   task automatic test_stall();
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      n_checks++;
      if (bus.pc !== 32'h10) $display("[TB] FAIL stall_start_pc: got %h want %h", bus.pc, 32'h10);
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 1, 0, 0, 0, 0, 1);
         n_checks++;
         if (bus.pc !== 32'h10 || bus.held !== 1'b1)
            $display("[TB] FAIL stall_hold[%0d]: got pc=%h held=%b want pc=00000010 held=1", i, bus.pc, bus.held);
         else n_pass++;
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      n_checks++;
      if (bus.pc !== 32'h14 || bus.held !== 1'b0)
         $display("[TB] FAIL stall_release: got pc=%h held=%b want pc=00000014 held=0", bus.pc, bus.held);
      else n_pass++;
   endtask

   task automatic test_pending_overwrite();
      applyStimulus(0, 0, 0, 0, 1, 32'h200, 0);
      applyStimulus(0, 0, 0, 0, 1, 32'h300, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (bus.pc !== 32'h14) $display("[TB] FAIL pending_hold_pc: got %h want %h", bus.pc, 32'h14);
      else n_pass++;
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      n_checks++;
      if (bus.pc !== 32'h300) $display("[TB] FAIL pending_load_pc: got %h want %h", bus.pc, 32'h300);
      else n_pass++;
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      n_checks++;
      if (bus.pc !== 32'h304) $display("[TB] FAIL pending_after_pc: got %h want %h", bus.pc, 32'h304);
      else n_pass++;
   endtask

   task automatic test_flush_priority();
      applyStimulus(0, 0, 0, 0, 1, 32'h500, 0);
      applyStimulus(0, 1, 1, 32'h180, 1, 32'h400, 1);
      n_checks++;
      if (bus.pc !== 32'h180) $display("[TB] FAIL flush_pc: got %h want %h", bus.pc, 32'h180);
      else n_pass++;
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      n_checks++;
      if (bus.pc !== 32'h184) $display("[TB] FAIL flush_next_pc: got %h want %h", bus.pc, 32'h184);
      else n_pass++;
   endtask

   task automatic test_wrap();
      applyStimulus(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      n_checks++;
      if (bus.pc !== 32'h0) $display("[TB] FAIL wrap_pc: got %h want %h", bus.pc, 32'h0);
      else n_pass++;
   endtask

   task automatic test_reset_mid_held();
      applyStimulus(0, 1, 0, 0, 0, 0, 1);
      applyStimulus(0, 1, 0, 0, 1, 32'h700, 1);
      n_checks++;
      if (bus.held !== 1'b1) $display("[TB] FAIL midreset_held_before: got %b want 1", bus.held);
      else n_pass++;
      applyStimulus(1, 1, 0, 0, 0, 0, 1);
      n_checks++;
      if (bus.pc !== 32'h0 || bus.ce !== 1'b0 || bus.held !== 1'b0)
         $display("[TB] FAIL midreset_state: got pc=%h ce=%b held=%b want pc=00000000 ce=0 held=0", bus.pc, bus.ce, bus.held);
      else n_pass++;
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      n_checks++;
      if (bus.pc !== 32'h4) $display("[TB] FAIL midreset_pending_dropped: got %h want %h", bus.pc, 32'h4);
      else n_pass++;
   endtask

`ifdef PC_MISALIGN_CHECK_EN
   task automatic test_misalign();
      applyStimulus(1, 0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 1, 32'h102, 1);
      n_checks++;
      if (bus.misalign !== 1'b1 || bus.ce !== 1'b0)
         $display("[TB] FAIL misalign_set: got mis=%b ce=%b want mis=1 ce=0", bus.misalign, bus.ce);
      else n_pass++;
      applyStimulus(0, 0, 1, 32'h100, 0, 0, 1);
      n_checks++;
      if (bus.misalign !== 1'b0 || bus.ce !== 1'b1 || bus.pc !== 32'h100)
         $display("[TB] FAIL misalign_clear: got mis=%b ce=%b pc=%h want mis=0 ce=1 pc=00000100", bus.misalign, bus.ce, bus.pc);
      else n_pass++;
   endtask
`endif

   // Random traffic with occasional resets, compared with the model on
   // every cycle.
   task automatic test_random();
      bit r, st, fl, br, rdy;
      logic [31:0] fpc, bt;
      for (int i = 0; i < 400; i++) begin
         r   = ($urandom_range(0, 49) == 0);
         st  = ($urandom_range(0, 3) == 0);
         fl  = ($urandom_range(0, 9) == 0);
         br  = ($urandom_range(0, 5) == 0);
         rdy = ($urandom_range(0, 3) != 0);
         fpc = $urandom;
         bt  = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            fpc[1:0] = 2'b00;
            bt[1:0]  = 2'b00;
         end
         applyStimulus(r, st, fl, fpc, br, bt, rdy);
         n_checks++;
         if (obs_fire !== exp_fire) $display("[TB] FAIL rand_fire[%0d]: got %b want %b", i, obs_fire, exp_fire);
         else n_pass++;
         n_checks++;
         if (bus.pc !== m_pc) $display("[TB] FAIL rand_pc[%0d]: got %h want %h", i, bus.pc, m_pc);
         else n_pass++;
         n_checks++;
         if (bus.ce !== m_ce || bus.held !== m_held)
            $display("[TB] FAIL rand_ctl[%0d]: got ce=%b held=%b want ce=%b held=%b", i, bus.ce, bus.held, m_ce, m_held);
         else n_pass++;
`ifdef PC_MISALIGN_CHECK_EN
         n_checks++;
         if (bus.misalign !== m_mis) $display("[TB] FAIL rand_mis[%0d]: got %b want %b", i, bus.misalign, m_mis);
         else n_pass++;
`endif
      end
   endtask

   initial begin
      m_pc     = 32'h0;
      m_ce     = 1'b0;
      m_held   = 1'b0;
      m_active = 1'b0;
      m_edges  = 0;
      m_mis    = 1'b0;
      rst               = 1'b1;
      bus.stall         = 1'b0;
      bus.flush         = 1'b0;
      bus.flush_pc      = '0;
      bus.branch_flag   = 1'b0;
      bus.branch_target = '0;
      bus.imem_ready    = 1'b1;
      test_reset();
      test_startup();
      test_stall();
      test_pending_overwrite();
      test_flush_priority();
      test_wrap();
      test_reset_mid_held();
`ifdef PC_MISALIGN_CHECK_EN
      test_misalign();
`endif
      test_random();
      $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Parametrised program-counter and fetch-request generator for the instruction fetch (IF) stage. It drives the instruction-memory address (pc) and chip enable (ce), and holds a ready/stall handshake with the instruction memory and the pipeline. It accepts flush (exception) and branch redirects, and buffers a branch that arrives while fetch is held, so no redirect is lost. It sits between the pipeline control unit and instruction memory, feeding the IF/ID register.

Parameters:
ADDR_W, 32, width of pc and of all target addresses
RESET_VEC, 0, pc value loaded on reset; first address fetched
INC, 4, byte increment per accepted fetch
HOLD_CYCLES, 1, cycles ce stays low after rst deasserts (1..15)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
stall  in  1  pipeline stall; while high, pc does not advance
flush  in  1  exception/flush redirect request
flush_pc  in  ADDR_W  flush target address
branch_flag  in  1  branch/jump redirect request
branch_target  in  ADDR_W  branch target address
imem_ready  in  1  instruction memory accepts the current request
pc  out  ADDR_W  fetch address (registered)
ce  out  1  instruction memory enable / request valid (registered)
fetch_fire  out  1  combinational: ce & imem_ready & ~stall
held  out  1  registered: 1 while FSM is in HELD

Behaviour:
- Reset is synchronous, active-high, on clock clk. While rst=1 at a rising edge: pc=RESET_VEC, ce=0, held=0, state=IDLE, hold counter=0, pending_vld=0, pending_pc=0. rst has priority over every other input and aborts any operation in progress.
- FSM states: IDLE, RUN, HELD.
- IDLE: counter increments each cycle. When counter==HOLD_CYCLES-1: ce<=1, state<=RUN, pc unchanged (=RESET_VEC). With HOLD_CYCLES=1, ce rises on the first edge after rst drops. All redirect inputs are ignored in IDLE.
- RUN and HELD: ce=1. The next pc is chosen by priority:
  1. flush=1: pc<=flush_pc next edge, regardless of stall or imem_ready. pending_vld<=0. A same-cycle branch is discarded.
  2. branch_flag=1 and fetch_fire=1: pc<=branch_target.
  3. branch_flag=1 and fetch_fire=0: pending_pc<=branch_target, pending_vld<=1, pc unchanged. A newer branch overwrites an older pending one.
  4. pending_vld=1 and fetch_fire=1: pc<=pending_pc, pending_vld<=0.
  5. fetch_fire=1: pc<=pc+INC, truncated to ADDR_W bits. Wraps modulo 2^ADDR_W, e.g. 0xFFFFFFFC -> 0x00000000.
  6. Otherwise pc holds.
- State transitions: RUN->HELD when fetch_fire=0 and flush=0. HELD->RUN when fetch_fire=1 or flush=1. held output = (state==HELD), registered.
- Latency: one redirect takes effect on the next edge. A buffered branch takes effect on the edge where fetch_fire first returns to 1.
- The address presented with ce=1 is stable until fetch_fire or flush.

Optional Feature:
PC_MISALIGN_CHECK_EN
- Defined: adds output misalign (1 bit, registered, reset 0). Any pc load (redirect or pending) with target[1:0]!=0 sets misalign<=1, and ce<=0 while misalign=1, so no fetch is issued. Only the next flush clears misalign, re-enables ce and loads flush_pc. If flush_pc is itself misaligned, misalign stays set.
- Not defined: port absent; targets are loaded unchanged, including low bits.

Test Plan:
- Reset release, defaults, imem_ready=1, stall=0: edge1 ce=1 pc=0x0; edge2 pc=0x4; edge3 pc=0x8. fetch_fire=1 from edge1.
- At pc=0x10, stall=1 for 3 cycles: pc holds 0x10, held=1 from next edge. Stall drops: pc=0x14 and held=0 on following edge.
- imem_ready=0 and branch_flag=1, target 0x200: pc holds, pending stored. Later target 0x300 while still not ready overwrites pending. imem_ready=1: pc=0x300, never 0x200.
- flush=1 (flush_pc=0x180) and branch_flag=1 (0x400) with stall=1: next edge pc=0x180, pending cleared, next pc 0x184.
- pc=0xFFFFFFFC, fetch accepted -> pc=0x00000000. rst pulsed mid-HELD with a branch pending -> pc=RESET_VEC, ce=0, pending dropped.
- With PC_MISALIGN_CHECK_EN: branch to 0x102 -> misalign=1, ce=0. Flush to 0x100 -> misalign=0, ce=1, pc=0x100.
